// File: rtl/lookup_result_drain_if.sv
// Result bus between the lookup pipeline, the drain buffer and its consumer.
// master drives results and accepts entries; slave is the drain buffer.
interface lookup_result_drain_if #(
  parameter int unsigned POINTER_SIZE      = 6,
  parameter int unsigned STRIDE_INDEX_SIZE = 3,
  parameter int unsigned SEQ_WIDTH         = 16
);
  logic                         res_valid;
  logic                         res_match;
  logic [POINTER_SIZE-1:0]      res_port;
  logic [STRIDE_INDEX_SIZE-1:0] res_stride;

  logic                         out_valid;
  logic                         out_ready;
  logic [SEQ_WIDTH-1:0]         out_seq;
  logic                         out_match;
  logic [POINTER_SIZE-1:0]      out_port;
  logic [STRIDE_INDEX_SIZE-1:0] out_stride;

  modport master (
    output res_valid, res_match, res_port, res_stride, out_ready,
    input  out_valid, out_seq, out_match, out_port, out_stride
  );

  modport slave (
    input  res_valid, res_match, res_port, res_stride, out_ready,
    output out_valid, out_seq, out_match, out_port, out_stride
  );
endinterface

// File: rtl/lookup_result_drain.sv
// Sequence-tagging result buffer between a non-stallable lookup pipeline and a
// consumer; first-word-fall-through with registered head, drop/match statistics.
module lookup_result_drain #(
  parameter int unsigned POINTER_SIZE      = 6,
  parameter int unsigned STRIDE_INDEX_SIZE = 3,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned SEQ_WIDTH         = 16,
  parameter int unsigned CNT_WIDTH         = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lookup_result_drain_if.slave         bus,
  input  logic                         clear_stats,
  output logic [$clog2(FIFO_DEPTH):0]  fill_level,
  output logic [CNT_WIDTH-1:0]         match_count,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic                         overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [SEQ_WIDTH-1:0]         seq;
    logic                         match;
    logic [POINTER_SIZE-1:0]      port;
    logic [STRIDE_INDEX_SIZE-1:0] stride;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        rd_ptr_nxt;
  logic [SEQ_WIDTH-1:0] seq;
  logic [LW-1:0]        fill_nxt;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;
  logic                 match_ev_c;
  entry_t               new_c;
  entry_t               head_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic ev);
    return (ev && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // Handshake decode and next head: a push landing on the next read slot bypasses memory.
  always_comb begin
    pop_c      = bus.out_valid & bus.out_ready;
    push_c     = bus.res_valid & ((fill_level < LW'(FIFO_DEPTH)) | pop_c);
    drop_c     = bus.res_valid & ~push_c;
    match_ev_c = bus.res_valid & bus.res_match;

    new_c.seq    = seq;
    new_c.match  = bus.res_match;
    new_c.port   = bus.res_match ? bus.res_port : '0;
    new_c.stride = bus.res_stride;

    fill_nxt = fill_level;
    if (push_c && !pop_c) begin
      fill_nxt = fill_level + LW'(1);
    end else if (pop_c && !push_c) begin
      fill_nxt = fill_level - LW'(1);
    end

    rd_ptr_nxt = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    head_nxt   = (push_c && (wr_ptr == rd_ptr_nxt)) ? new_c : mem[rd_ptr_nxt];
  end

  // Storage array; pointers carry the reset, so contents need none.
  always_ff @(posedge clk) begin
    if (push_c && rst_n) begin
      mem[wr_ptr] <= new_c;
    end
  end

  // Pointers, occupancy, sequence tag and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_seq    <= '0;
      bus.out_match  <= 1'b0;
      bus.out_port   <= '0;
      bus.out_stride <= '0;
    end else begin
      if (bus.res_valid) begin
        seq <= seq + SEQ_WIDTH'(1);
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr         <= rd_ptr_nxt;
      fill_level     <= fill_nxt;
      bus.out_valid  <= (fill_nxt != '0);
      bus.out_seq    <= head_nxt.seq;
      bus.out_match  <= head_nxt.match;
      bus.out_port   <= head_nxt.port;
      bus.out_stride <= head_nxt.stride;
    end
  end

  // Statistics; a clear keeps only the event of its own cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (clear_stats) begin
      match_count <= CNT_WIDTH'(match_ev_c);
      drop_count  <= CNT_WIDTH'(drop_c);
      overflow    <= drop_c;
    end else begin
      match_count <= sat_inc(match_count, match_ev_c);
      drop_count  <= sat_inc(drop_count, drop_c);
      overflow    <= overflow | drop_c;
    end
  end
endmodule

// File: tb/tb_lookup_result_drain.sv
// Scoreboard bench for lookup_result_drain: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_lookup_result_drain;
  localparam int unsigned PS   = 6;
  localparam int unsigned SS   = 3;
  localparam int unsigned D    = 8;
  localparam int unsigned SW   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned LW   = $clog2(D) + 1;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear_stats = 1'b0;
  logic [LW-1:0] fill_level;
  logic [CW-1:0] match_count;
  logic [CW-1:0] drop_count;
  logic          overflow;

  lookup_result_drain_if #(.POINTER_SIZE(PS), .STRIDE_INDEX_SIZE(SS), .SEQ_WIDTH(SW)) bus ();

  lookup_result_drain #(
    .POINTER_SIZE(PS), .STRIDE_INDEX_SIZE(SS), .FIFO_DEPTH(D),
    .SEQ_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clear_stats(clear_stats),
    .fill_level(fill_level), .match_count(match_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seq;
    int match;
    int port;
    int stride;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_fill = 0;
  int   m_seq = 0;
  int   m_match = 0;
  int   m_drop = 0;
  int   m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted head entry must match the oldest expected result.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_seq", 32'(bus.out_seq), 32'(mon_e.seq));
        chk("out_match", 32'(bus.out_match), 32'(mon_e.match));
        chk("out_port", 32'(bus.out_port), 32'(mon_e.port));
        chk("out_stride", 32'(bus.out_stride), 32'(mon_e.stride));
      end
    end
  end

  // Drive one cycle of inputs, advance the model, then check state after the edge.
  task automatic step(input bit v, input bit m, input int p, input int s,
                      input bit rdy, input bit clr);
    bit   pop_m, push_m, ev_match, ev_drop;
    exp_t e;
    bus.res_valid  = v;
    bus.res_match  = m;
    bus.res_port   = PS'(p);
    bus.res_stride = SS'(s);
    bus.out_ready  = rdy;
    clear_stats    = clr;
    if (rst_n) begin
      pop_m  = (m_fill != 0) && rdy;
      push_m = v && ((m_fill < D) || pop_m);
      if (v) begin
        if (push_m) begin
          e.seq = m_seq; e.match = int'(m); e.port = m ? p : 0; e.stride = s;
          exp_q.push_back(e);
        end
        m_seq = (m_seq + 1) % (1 << SW);
      end
      m_fill   = m_fill + int'(push_m) - int'(pop_m);
      ev_match = v && m;
      ev_drop  = v && !push_m;
      if (clr) begin
        m_match = int'(ev_match); m_drop = int'(ev_drop); m_ovf = int'(ev_drop);
      end else begin
        if (ev_match && m_match < CMAX) m_match++;
        if (ev_drop && m_drop < CMAX) m_drop++;
        if (ev_drop) m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("fill_level", 32'(fill_level), 32'(m_fill));
    chk("out_valid", 32'(bus.out_valid), 32'(m_fill != 0));
    chk("match_count", 32'(match_count), 32'(m_match));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    #1;
  endtask

  task automatic step_rand(input bit v, input bit rdy);
    step(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
         int'($urandom_range(0, 7)), rdy, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear immediately, inputs are ignored meanwhile.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    m_fill = 0; m_seq = 0; m_match = 0; m_drop = 0; m_ovf = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fill_level", 32'(fill_level), 32'd0);
    chk("rst_out_seq", 32'(bus.out_seq), 32'd0);
    chk("rst_out_port", 32'(bus.out_port), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 7, 1, 1'($urandom_range(0, 1)), 1'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < int'(D) + 2; i++) step_rand(1'b0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.res_valid = 1'b0; bus.res_match = 1'b0; bus.res_port = '0;
    bus.res_stride = '0; bus.out_ready = 1'b0;
    #1;
    do_reset(2);

    // Single pass-through with latency one.
    step(1'b1, 1'b1, 5, 3, 1'b1, 1'b0);
    chk("pt_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pt_out_seq", 32'(bus.out_seq), 32'd0);
    chk("pt_out_port", 32'(bus.out_port), 32'd5);
    chk("pt_out_stride", 32'(bus.out_stride), 32'd3);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("pt_empty", 32'(bus.out_valid), 32'd0);
    chk("pt_match_count", 32'(match_count), 32'd1);

    // Overflow: two of ten dropped, then tag gap visible.
    do_reset(1);
    for (int i = 0; i < 10; i++) step_rand(1'b1, 1'b0);
    chk("ovf_fill", 32'(fill_level), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step_rand(1'b0, 1'b1);
    step_rand(1'b1, 1'b1);
    chk("ovf_next_seq", 32'(bus.out_seq), 32'd10);
    drain();

    // Full with simultaneous push and pop: nothing dropped.
    do_reset(1);
    for (int i = 0; i < 8; i++) step_rand(1'b1, 1'b0);
    step_rand(1'b1, 1'b1);
    chk("fpp_fill", 32'(fill_level), 32'd8);
    chk("fpp_drop", 32'(drop_count), 32'd0);
    drain();

    // No-match masking, then counter saturation.
    do_reset(1);
    step(1'b1, 1'b0, 63, 2, 1'b0, 1'b0);
    chk("mask_port", 32'(bus.out_port), 32'd0);
    chk("mask_match_count", 32'(match_count), 32'd0);
    drain();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, int'($urandom_range(0, 63)), 0, 1'b1, 1'b0);
    chk("sat_match_count", 32'(match_count), 32'd15);
    drain();

    // Clear with same-cycle drop.
    do_reset(1);
    for (int i = 0; i < 10; i++) step_rand(1'b1, 1'b0);
    step(1'b1, 1'b1, 9, 4, 1'b0, 1'b1);
    chk("clr_drop", 32'(drop_count), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd1);
    chk("clr_match", 32'(match_count), 32'd1);
    step_rand(1'b0, 1'b0);
    drain();

    // Reset mid-stream with four buffered.
    for (int i = 0; i < 4; i++) step_rand(1'b1, 1'b0);
    chk("mid_fill", 32'(fill_level), 32'd4);
    do_reset(2);
    step_rand(1'b1, 1'b1);
    chk("mid_first_seq", 32'(bus.out_seq), 32'd0);
    drain();

    // Sequence wrap over 17 results.
    do_reset(1);
    for (int i = 0; i < 17; i++) step_rand(1'b1, 1'b1);
    drain();

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 19) == 0));
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lookup_result_drain.md
LOOKUP_RESULT_DRAIN -- requirements
Module: lookup_result_drain

Interface
REQ-001 SHALL have parameter POINTER_SIZE, default 6, width of next-hop/port pointer.
REQ-002 SHALL have parameter STRIDE_INDEX_SIZE, default 3, width of matched stride index.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, result buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter SEQ_WIDTH, default 16, name sequence tag width.
REQ-005 SHALL have parameter CNT_WIDTH, default 32, statistics counter width.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port res_valid  in  1  lookup pipeline presents one result this cycle; no backpressure to pipeline.
REQ-009 SHALL have port res_match  in  1  name matched a FIB entry.
REQ-010 SHALL have port res_port  in  POINTER_SIZE  matched next-hop pointer.
REQ-011 SHALL have port res_stride  in  STRIDE_INDEX_SIZE  stride index of longest match.
REQ-012 SHALL have port out_valid  out  1  head entry available.
REQ-013 SHALL have port out_ready  in  1  consumer accepts head entry.
REQ-014 SHALL have ports out_seq (SEQ_WIDTH), out_match (1), out_port (POINTER_SIZE), out_stride (STRIDE_INDEX_SIZE)  out  head entry fields.
REQ-015 SHALL have port fill_level  out  log2(FIFO_DEPTH)+1  entries currently buffered.
REQ-016 SHALL have ports match_count, drop_count  out  CNT_WIDTH  saturating statistics.
REQ-017 SHALL have port overflow  out  1  sticky: at least one result dropped since reset/clear.
REQ-018 SHALL have port clear_stats  in  1  synchronous clear of match_count, drop_count, overflow.

Function
REQ-019 SHALL keep a sequence counter seq; each cycle with res_valid=1 the result is tagged with seq and seq increments by 1 modulo 2^SEQ_WIDTH, whether stored or dropped, so dropped results leave tag gaps.
REQ-020 SHALL define pop = out_valid & out_ready; push = res_valid & (fill_level < FIFO_DEPTH | pop).
REQ-021 SHALL, when full and pop occurs in the same cycle as res_valid, both pop head and store the new result; fill_level stays FIFO_DEPTH.
REQ-022 SHALL store out_port as 0 for entries with res_match=0, regardless of res_port.
REQ-023 SHALL be first-word-fall-through: out_valid = (fill_level != 0); head fields stable while out_valid=1 and out_ready=0.
REQ-024 SHALL present a result pushed into an empty FIFO on out_* in the cycle after res_valid is sampled (latency 1); out_* are don't-care when out_valid=0.
REQ-025 SHALL update fill_level +1 on push only, -1 on pop only, unchanged on both or neither; read/write pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL treat out_ready=1 with empty FIFO as no-op.
REQ-027 SHALL increment match_count on each pushed or dropped result with res_match=1; saturate at 2^CNT_WIDTH-1.
REQ-028 SHALL, when res_valid=1 and push=0, discard the result, increment drop_count (saturating), set overflow.
REQ-029 SHALL, on clear_stats=1, load counters with the same-cycle event only (0 or 1) and overflow with same-cycle drop; FIFO contents and seq unaffected.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force seq=0, pointers=0, fill_level=0, out_valid=0, match_count=0, drop_count=0, overflow=0; out_seq/out_match/out_port/out_stride = 0.
REQ-031 SHALL, on reset asserted mid-operation, discard all buffered entries; first result after deassertion gets out_seq=0.
REQ-032 SHALL ignore res_valid and out_ready while rst_n=0; first sampling edge is the first rising clk with rst_n=1.

Verification
REQ-033 SHALL verify single pass-through: after reset, res_valid=1, match=1, port=5, stride=3, out_ready=1 -> next cycle out_valid=1, out_seq=0, out_port=5, out_stride=3; following cycle out_valid=0, match_count=1.
REQ-034 SHALL verify overflow: out_ready=0, 10 consecutive res_valid (DEPTH 8) -> fill_level=8, drop_count=2, overflow=1; draining yields out_seq 0..7 in order; next accepted result carries out_seq=10.
REQ-035 SHALL verify full with simultaneous push/pop: FIFO full, res_valid=1 and out_ready=1 same cycle -> drop_count unchanged, fill_level=8, new entry emerges last.
REQ-036 SHALL verify no-match masking and saturation: res_match=0, res_port=63 -> out_port=0, match_count unchanged; with CNT_WIDTH=4, 20 matches -> match_count=15.
REQ-037 SHALL verify clear/reset: clear_stats with same-cycle drop -> drop_count=1, overflow=1; rst_n pulsed low mid-stream with 4 buffered -> out_valid=0, fill_level=0 immediately, next result out_seq=0.
REQ-038 SHALL verify seq wrap: SEQ_WIDTH=4, 17 results drained -> out_seq sequence 0..15, 0.
